// File: rtl/i4004_bus_timing_pkg.sv
// Shared constants and helpers for the 4004 CPU-side bus timing unit.
// Phase indices follow the machine-cycle order A1 A2 A3 M1 M2 E1 E2 E3.
package i4004_bus_timing_pkg;

    localparam logic [3:0] OP_SRC = 4'h2;
    localparam logic [3:0] OP_IOR = 4'hE;

    localparam int NUM_PHASES = 8;
    localparam int PH_A1 = 0;
    localparam int PH_A2 = 1;
    localparam int PH_A3 = 2;
    localparam int PH_M1 = 3;
    localparam int PH_M2 = 4;
    localparam int PH_E1 = 5;
    localparam int PH_E2 = 6;
    localparam int PH_E3 = 7;

    typedef logic [NUM_PHASES-1:0] phase_t;

    localparam phase_t PHASE_RESET = 8'b1000_0000;

    // Read-type I/O functions occupy the upper half of the OPA space.
    function automatic logic fn_is_read(input logic [3:0] opa_v);
        return (opa_v >= 4'd8);
    endfunction

    function automatic phase_t phase_rotate(input phase_t ph_v);
        return {ph_v[NUM_PHASES-2:0], ph_v[NUM_PHASES-1]};
    endfunction

endpackage

// File: rtl/i4004_bus_timing_phase_ring.sv
// One-hot 8-phase machine-cycle ring shared by the CPU and the ROM/RAM models.
// Resets to E3 so the first clock after reset release lands in A1.
module mcs4_phase_ring
    import i4004_bus_timing_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    output phase_t phase_o
);

    phase_t phase_q;
    phase_t phase_d;

    // A corrupted (non one-hot) ring falls back to E3 and realigns on the next cycle.
    always_comb begin
        phase_d = PHASE_RESET;
        if ($onehot(phase_q)) begin
            phase_d = phase_rotate(phase_q);
        end else begin
            phase_d = PHASE_RESET;
        end
    end

    // Phase register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= PHASE_RESET;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/i4004_bus_timing.sv
// 4004 CPU-side bus interface: address out, instruction fetch, SRC/I-O execute and command lines.
// Every output is registered on the cp2 edge that enters the phase in which it is valid.
module i4004_bus_timing
    import i4004_bus_timing_pkg::*;
#(
    parameter int RAM_BANKS = 4
) (
    input  logic                 cp1,
    input  logic                 cp2,
    input  logic                 reset,
    inout  wire  [3:0]           data,
    output logic                 sync,
    output logic                 cm_rom,
    output logic [RAM_BANKS-1:0] cm_ram,
    input  logic [11:0]          pc,
    input  logic [1:0]           ram_bank,
    input  logic [3:0]           acc,
    input  logic [7:0]           rp_data,
    output logic [3:0]           opr,
    output logic [3:0]           opa,
    output logic                 instr_valid,
    output logic [3:0]           rd_data,
    output logic                 rd_valid
);

    phase_t               phase_s;
    logic [RAM_BANKS-1:0] bank_hot_s;
    logic                 exec_src_s;
    logic                 exec_wr_s;
    logic                 exec_rd_s;

    logic [7:0]           pc_hi_q, pc_hi_d;
    logic [3:0]           opr_stage_q, opr_stage_d;
    logic [3:0]           opr_q, opr_d;
    logic [3:0]           opa_q, opa_d;
    logic [3:0]           rd_data_q, rd_data_d;
    logic [3:0]           drv_q, drv_d;
    logic                 drv_en_q, drv_en_d;
    logic                 sync_q, sync_d;
    logic                 cm_rom_q, cm_rom_d;
    logic [RAM_BANKS-1:0] cm_ram_q, cm_ram_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 rd_valid_q, rd_valid_d;

    mcs4_phase_ring u_ring (
        .clk_i   (cp2),
        .rst_n_i (reset),
        .phase_o (phase_s)
    );

    // One-hot RAM select; banks beyond RAM_BANKS simply match no line.
    always_comb begin
        bank_hot_s = '0;
        for (int i = 0; i < RAM_BANKS; i++) begin
            if (int'(ram_bank) == i) begin
                bank_hot_s[i] = 1'b1;
            end else begin
                bank_hot_s[i] = 1'b0;
            end
        end
    end

    assign exec_src_s = (opr_q == OP_SRC) && opa_q[0];
    assign exec_wr_s  = (opr_q == OP_IOR) && !fn_is_read(opa_q);
    assign exec_rd_s  = (opr_q == OP_IOR) && fn_is_read(opa_q);

    // Next-state: each branch is the phase being left, so it sets up the phase being entered.
    always_comb begin
        pc_hi_d       = pc_hi_q;
        opr_stage_d   = opr_stage_q;
        opr_d         = opr_q;
        opa_d         = opa_q;
        rd_data_d     = rd_data_q;
        drv_d         = 4'h0;
        drv_en_d      = 1'b0;
        sync_d        = phase_s[PH_E2];
        instr_valid_d = phase_s[PH_M2];
        cm_rom_d      = 1'b0;
        cm_ram_d      = '0;
        rd_valid_d    = 1'b0;

        if (phase_s[PH_E3]) begin
            pc_hi_d  = pc[11:4];
            drv_d    = pc[3:0];
            drv_en_d = 1'b1;
        end else if (phase_s[PH_A1]) begin
            drv_d    = pc_hi_q[3:0];
            drv_en_d = 1'b1;
        end else if (phase_s[PH_A2]) begin
            drv_d    = pc_hi_q[7:4];
            drv_en_d = 1'b1;
            cm_rom_d = 1'b1;
        end else if (phase_s[PH_A3]) begin
            drv_en_d = 1'b0;
        end else if (phase_s[PH_M1]) begin
            // OPR is staged here so opr stays stable until the whole instruction is in.
            opr_stage_d = data;
            if (data == OP_IOR) begin
                cm_rom_d = 1'b1;
                cm_ram_d = bank_hot_s;
            end else begin
                cm_rom_d = 1'b0;
                cm_ram_d = '0;
            end
        end else if (phase_s[PH_M2]) begin
            opr_d = opr_stage_q;
            opa_d = data;
        end else if (phase_s[PH_E1]) begin
            if (exec_src_s || exec_wr_s) begin
                cm_rom_d = 1'b1;
                cm_ram_d = bank_hot_s;
                drv_en_d = 1'b1;
                drv_d    = exec_src_s ? rp_data[7:4] : acc;
            end else begin
                cm_rom_d = 1'b0;
                drv_en_d = 1'b0;
            end
        end else if (phase_s[PH_E2]) begin
            if (exec_rd_s) begin
                rd_data_d  = data;
                rd_valid_d = 1'b1;
            end else begin
                rd_valid_d = 1'b0;
            end
            if (exec_src_s) begin
                drv_d    = rp_data[3:0];
                drv_en_d = 1'b1;
            end else begin
                drv_en_d = 1'b0;
            end
        end else begin
            drv_en_d = 1'b0;
        end
    end

    // State and output registers; reset discards any partial fetch.
    always_ff @(posedge cp2 or negedge reset) begin
        if (!reset) begin
            pc_hi_q       <= 8'h00;
            opr_stage_q   <= 4'h0;
            opr_q         <= 4'h0;
            opa_q         <= 4'h0;
            rd_data_q     <= 4'h0;
            drv_q         <= 4'h0;
            drv_en_q      <= 1'b0;
            sync_q        <= 1'b0;
            cm_rom_q      <= 1'b0;
            cm_ram_q      <= '0;
            instr_valid_q <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            pc_hi_q       <= pc_hi_d;
            opr_stage_q   <= opr_stage_d;
            opr_q         <= opr_d;
            opa_q         <= opa_d;
            rd_data_q     <= rd_data_d;
            drv_q         <= drv_d;
            drv_en_q      <= drv_en_d;
            sync_q        <= sync_d;
            cm_rom_q      <= cm_rom_d;
            cm_ram_q      <= cm_ram_d;
            instr_valid_q <= instr_valid_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // The bus is released while cp1 is high, leaving it free for precharge.
    assign data        = (drv_en_q && !cp1) ? drv_q : 4'bzzzz;
    assign sync        = sync_q;
    assign cm_rom      = cm_rom_q;
    assign cm_ram      = cm_ram_q;
    assign opr         = opr_q;
    assign opa         = opa_q;
    assign instr_valid = instr_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_i4004_bus_timing.sv
// Self-checking bench for i4004_bus_timing: the bench plays the ROM/RAM side of the bus
// and predicts every phase of each machine cycle from the instruction it serves.
module tb_i4004_bus_timing;

    localparam int NB  = 4;
    localparam int NB2 = 2;

    logic        cp1, cp2, reset;
    logic [11:0] pc;
    logic [1:0]  ram_bank;
    logic [3:0]  acc;
    logic [7:0]  rp_data;
    logic        tb_oe;
    logic [3:0]  tb_drv;

    // Pulled-up buses: an undriven bus reads as 4'hF.
    tri1 [3:0]   data_bus;
    tri1 [3:0]   data_bus2;
    assign data_bus  = tb_oe ? tb_drv : 4'bzzzz;
    assign data_bus2 = tb_oe ? tb_drv : 4'bzzzz;

    logic          sync, cm_rom, instr_valid, rd_valid;
    logic [NB-1:0] cm_ram;
    logic [3:0]    opr, opa, rd_data;
    logic          sync2, cm_rom2, instr_valid2, rd_valid2;
    logic [NB2-1:0] cm_ram2;
    logic [3:0]    opr2, opa2, rd_data2;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_opr, m_opa, m_rd;

    i4004_bus_timing #(.RAM_BANKS(NB)) dut (
        .cp1(cp1), .cp2(cp2), .reset(reset), .data(data_bus), .sync(sync),
        .cm_rom(cm_rom), .cm_ram(cm_ram), .pc(pc), .ram_bank(ram_bank), .acc(acc),
        .rp_data(rp_data), .opr(opr), .opa(opa), .instr_valid(instr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    i4004_bus_timing #(.RAM_BANKS(NB2)) dut2 (
        .cp1(cp1), .cp2(cp2), .reset(reset), .data(data_bus2), .sync(sync2),
        .cm_rom(cm_rom2), .cm_ram(cm_ram2), .pc(pc), .ram_bank(ram_bank), .acc(acc),
        .rp_data(rp_data), .opr(opr2), .opa(opa2), .instr_valid(instr_valid2),
        .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    // cp2 rises at 10, 30, 50 ...; cp1 is high 2..6 of each 20-unit period.
    initial begin
        cp2 = 1'b0;
        forever begin
            #10 cp2 = 1'b1;
            #4  cp2 = 1'b0;
            #6;
        end
    end

    initial begin
        cp1 = 1'b0;
        forever begin
            #2 cp1 = 1'b1;
            #4 cp1 = 1'b0;
            #14;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One full machine cycle; entered and left in the middle of E3 (or during reset release).
    task automatic run_cycle(input logic [3:0] opr_v, input logic [3:0] opa_v,
                             input logic [11:0] pc_v, input logic [7:0] rp_v,
                             input logic [3:0] acc_v, input logic [3:0] rd_v,
                             input logic [1:0] bank_v);
        logic        is_src, is_wr, is_rd, sel;
        logic [3:0]  e_data;
        logic [23:0] obs_v, exp_v;
        logic [7:0]  obs2_v, exp2_v;
        is_src = (opr_v == 4'h2) && (opa_v[0] == 1'b1);
        is_wr  = (opr_v == 4'hE) && (opa_v < 4'd8);
        is_rd  = (opr_v == 4'hE) && (opa_v >= 4'd8);
        pc = pc_v;
        for (int p = 0; p < 8; p++) begin
            @(posedge cp2);
            #1;
            tb_oe  = (p == 3) || (p == 4) || (p == 6 && is_rd);
            tb_drv = (p == 3) ? opr_v : ((p == 4) ? opa_v : rd_v);
            if (p == 0) begin
                pc       = 12'($urandom);
                rp_data  = rp_v;
                acc      = acc_v;
                ram_bank = bank_v;
            end
            #4;
            case (p)
                0:       e_data = pc_v[3:0];
                1:       e_data = pc_v[7:4];
                2:       e_data = pc_v[11:8];
                3:       e_data = opr_v;
                4:       e_data = opa_v;
                6:       e_data = is_src ? rp_v[7:4] : (is_wr ? acc_v : (is_rd ? rd_v : 4'hF));
                7:       e_data = is_src ? rp_v[3:0] : 4'hF;
                default: e_data = 4'hF;
            endcase
            sel = (p == 4 && opr_v == 4'hE) || (p == 6 && (is_src || is_wr));
            if (p == 5) begin
                m_opr = opr_v;
                m_opa = opa_v;
            end
            if (p == 7 && is_rd) m_rd = rd_v;
            exp_v = {(p == 7), (p == 2) || sel,
                     (sel && int'(bank_v) < NB) ? 4'(1 << bank_v) : 4'h0,
                     e_data, (p == 5), (p == 7) && is_rd, m_opr, m_opa, m_rd};
            obs_v = {sync, cm_rom, cm_ram, data_bus, instr_valid, rd_valid, opr, opa, rd_data};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL phase%0d opr=%h opa=%h bank=%0d: got %h required %h",
                         p, opr_v, opa_v, bank_v, obs_v, exp_v);
            end
            exp2_v = {(p == 7), (p == 2) || sel,
                      (sel && int'(bank_v) < NB2) ? 2'(1 << bank_v) : 2'b00, e_data};
            obs2_v = {sync2, cm_rom2, cm_ram2, data_bus2};
            checks++;
            if (obs2_v !== exp2_v) begin
                failures++;
                $display("FAIL banks2_phase%0d opr=%h opa=%h bank=%0d: got %h required %h",
                         p, opr_v, opa_v, bank_v, obs2_v, exp2_v);
            end
        end
    endtask

    task automatic test_reset();
        logic [23:0] obs_v;
        tb_oe = 1'b0; tb_drv = 4'h0; pc = 12'h000; ram_bank = 2'd0; acc = 4'h0; rp_data = 8'h00;
        m_opr = 4'h0; m_opa = 4'h0; m_rd = 4'h0;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #5;
            obs_v = {sync, cm_rom, cm_ram, data_bus, instr_valid, rd_valid, opr, opa, rd_data};
            checks++;
            if (obs_v !== 24'h03C000) begin
                failures++;
                $display("FAIL reset_hold%0d: got %h required %h", k, obs_v, 24'h03C000);
            end
            #35;
        end
        reset = 1'b1;
    endtask

    // Assert reset in the middle of phase stop_p, check outputs at once, then release.
    task automatic test_reset_mid(input int stop_p);
        logic [23:0] obs_v;
        logic [7:0]  obs2_v;
        for (int p = 0; p <= stop_p; p++) @(posedge cp2);
        #5;
        reset = 1'b0;
        tb_oe = 1'b0;
        #1;
        obs_v  = {sync, cm_rom, cm_ram, data_bus, instr_valid, rd_valid, opr, opa, rd_data};
        obs2_v = {sync2, cm_rom2, cm_ram2, data_bus2};
        checks++;
        if (obs_v !== 24'h03C000) begin
            failures++;
            $display("FAIL reset_mid_phase%0d: got %h required %h", stop_p, obs_v, 24'h03C000);
        end
        checks++;
        if (obs2_v !== 8'h0F) begin
            failures++;
            $display("FAIL reset_mid_banks2_phase%0d: got %h required %h", stop_p, obs2_v, 8'h0F);
        end
        m_opr = 4'h0; m_opa = 4'h0; m_rd = 4'h0;
        #3;
        reset = 1'b1;
    endtask

    task automatic test_address();
        run_cycle(4'hD, 4'h3, 12'h2A5, 8'h5C, 4'h1, 4'h0, 2'd1);
    endtask

    task automatic test_src();
        run_cycle(4'h2, 4'h1, 12'h1E3, 8'h47, 4'hB, 4'h0, 2'd2);
    endtask

    task automatic test_wrr();
        run_cycle(4'hE, 4'h2, 12'h3C8, 8'hA1, 4'h9, 4'h0, 2'd0);
    endtask

    task automatic test_rdr();
        run_cycle(4'hE, 4'hA, 12'h7B4, 8'h33, 4'h2, 4'h6, 2'd1);
    endtask

    task automatic test_bank_limit();
        run_cycle(4'h2, 4'h1, 12'h456, 8'h9E, 4'h4, 4'h0, 2'd3);
        run_cycle(4'hE, 4'h0, 12'h0F1, 8'h12, 4'h5, 4'h0, 2'd3);
    endtask

    task automatic test_back_to_back(input int n);
        logic [3:0] opr_v;
        for (int c = 0; c < n; c++) begin
            case ($urandom_range(0, 2))
                0:       opr_v = 4'h2;
                1:       opr_v = 4'hE;
                default: opr_v = 4'($urandom);
            endcase
            run_cycle(opr_v, 4'($urandom), 12'($urandom), 8'($urandom),
                      4'($urandom), 4'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_address();
        test_src();
        test_wrr();
        test_rdr();
        test_reset_mid(3);
        test_address();
        test_rdr();
        test_reset_mid(1);
        test_src();
        test_bank_limit();
        test_back_to_back(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
